// File: rtl/spi_master_ctrl.sv
// SPI master: turns host valid/ready requests into 10-bit frames (2 command bits,
// then 8 data bits, MSB first) and collects the 8-bit reply of read-data frames.
module spi_master_ctrl #(
    parameter int RD_LATENCY = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [1:0] tx_cmd,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic             rd_q, rd_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             ss_n_q, ss_n_d;
    logic             mosi_q, mosi_d;
    logic             accept;

    assign accept = tx_valid && (state_q == S_IDLE);

    // NOTE: every variable gets a default at the top of the block, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        rd_d       = rd_q;
        rx_shift_d = rx_shift_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_START;
                    frame_d = {tx_cmd, tx_data};
                    rd_d    = (tx_cmd == 2'b11);
                    cnt_d   = '0;
                end
            end
            S_START: begin
                state_d = S_SHIFT;
                cnt_d   = '0;
            end
            S_SHIFT: begin
                if (cnt_q == SHIFT_LAST) begin
                    cnt_d = '0;
                    if (!rd_q)               state_d = S_DONE;
                    else if (RD_LATENCY > 0) state_d = S_WAIT;
                    else                     state_d = S_READ;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    frame_d = {frame_q[8:0], 1'b0};
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = S_READ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_READ: begin
                rx_shift_d = {rx_shift_q[6:0], MISO};
                if (cnt_q == READ_LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Pin outputs are registered, so they are derived from the state being entered.
    always_comb begin
        ss_n_d     = (state_d == S_IDLE) || (state_d == S_DONE);
        mosi_d     = (state_d == S_SHIFT) ? frame_d[9] : 1'b0;
        rx_valid_d = (state_q == S_READ) && (state_d == S_DONE);
        rx_data_d  = rx_valid_d ? rx_shift_d : rx_data_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            rd_q       <= 1'b0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            rd_q       <= rd_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
        end
    end

    assign tx_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign SS_n     = ss_n_q;
    assign MOSI     = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: the stimulus queues expected frames, and a
// negedge monitor (which also plays the SPI slave with a small RAM) checks each frame.
module tb_spi_master_ctrl;

    localparam int RD_LATENCY = 1;

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic [7:0] rx;
        int         len;
        int         gap;
        bit         abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [1:0] tx_cmd = 2'b00;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t cur;
    bit   have_cur = 1'b0;
    bit   in_frame = 1'b0;

    logic       prev_ss = 1'b1;
    int         low_cnt = 0;
    int         high_cnt = 0;
    logic [9:0] bits = '0;
    bit         pend_ready = 1'b0;
    bit         have_exp;

    logic [7:0] mem [256];
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_byte = 8'h00;

    spi_master_ctrl #(.RD_LATENCY(RD_LATENCY), .CNT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_cmd   (tx_cmd),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + slave model, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (SS_n === 1'b0) begin
            if (prev_ss !== 1'b0) begin
                in_frame = 1'b1;
                low_cnt  = 1;
                bits     = '0;
                have_exp = (exp_q.size() > 0);
                check("frame_expected", {31'd0, have_exp}, 32'd1);
                if (have_exp) begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    if (cur.gap >= 0) check("ss_high_gap", high_cnt, cur.gap);
                end else begin
                    have_cur = 1'b0;
                end
                check("mosi_start", {31'd0, MOSI}, 32'd0);
            end else begin
                low_cnt++;
                if (low_cnt >= 2 && low_cnt <= 11) bits = {bits[8:0], MOSI};
                else check("mosi_quiet", {31'd0, MOSI}, 32'd0);
                if (low_cnt == 11) begin
                    case (bits[9:8])
                        2'b00: wr_addr = bits[7:0];
                        2'b01: mem[wr_addr] = bits[7:0];
                        2'b10: rd_addr = bits[7:0];
                        default: rd_byte = mem[rd_addr];
                    endcase
                end
            end
            check("rx_valid_in_frame", {31'd0, rx_valid}, 32'd0);
            if (low_cnt >= 12 + RD_LATENCY && low_cnt <= 19 + RD_LATENCY)
                MISO = rd_byte[7 - (low_cnt - 12 - RD_LATENCY)];
            else
                MISO = 1'b1;
        end else begin
            MISO = 1'b1;
            check("mosi_ss_high", {31'd0, MOSI}, 32'd0);
            if (prev_ss === 1'b0) begin
                in_frame = 1'b0;
                high_cnt = 1;
                if (have_cur) begin
                    check("ss_low_len", low_cnt, cur.len);
                    if (!cur.abort) check("frame_bits", {22'd0, bits}, {22'd0, cur.cmd, cur.data});
                    if (cur.cmd == 2'b11 && !cur.abort) begin
                        check("rx_valid_done", {31'd0, rx_valid}, 32'd1);
                        check("rx_data_done", {24'd0, rx_data}, {24'd0, cur.rx});
                    end else begin
                        check("rx_valid_none", {31'd0, rx_valid}, 32'd0);
                        if (cur.abort) check("rx_data_abort", {24'd0, rx_data}, 32'd0);
                    end
                end
                pend_ready = 1'b1;
            end else begin
                high_cnt++;
                check("rx_valid_idle", {31'd0, rx_valid}, 32'd0);
                if (pend_ready) check("tx_ready_after", {31'd0, tx_ready}, 32'd1);
                pend_ready = 1'b0;
            end
        end
        prev_ss = SS_n;
    end

    task automatic issue(input logic [1:0] cmd, input logic [7:0] data, input logic [7:0] rx,
                         input int len, input int gap, input bit abort);
        exp_t e;
        int   n = 0;
        tx_valid = 1'b1;
        tx_cmd   = cmd;
        tx_data  = data;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) check("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        e.cmd = cmd; e.data = data; e.rx = rx; e.len = len; e.gap = gap; e.abort = abort;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h3C;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ss_n", {31'd0, SS_n}, 32'd1);
        check("rst_mosi", {31'd0, MOSI}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Write address 0xA5: bits 00_1010_0101.
        issue(2'b00, 8'hA5, 8'h00, 11, -1, 1'b0);
        tx_valid = 1'b0;
        check("busy_in_frame", {31'd0, busy}, 32'd1);
        repeat (14) @(posedge clk);
        #1;

        // Read data from address 0 (slave holds 0x3C there).
        issue(2'b11, 8'h00, 8'h3C, 20, -1, 1'b0);
        tx_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;

        // Back-to-back burst with tx_valid held high.
        issue(2'b00, 8'h10, 8'h00, 11, -1, 1'b0);
        issue(2'b01, 8'h77, 8'h00, 11, 2, 1'b0);
        issue(2'b10, 8'h10, 8'h00, 11, 2, 1'b0);
        issue(2'b11, 8'h00, 8'h77, 20, 2, 1'b0);
        tx_valid = 1'b0;
        repeat (24) @(posedge clk);
        #1;

        // Busy protection: a competing request at T+5 must be ignored.
        issue(2'b01, 8'h5A, 8'h00, 11, -1, 1'b0);
        tx_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_cmd   = 2'b01;
        tx_data  = 8'hFF;
        check("busy_tx_ready", {31'd0, tx_ready}, 32'd0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        // Reset at T+6 of a read-data frame.
        issue(2'b11, 8'h00, 8'h00, 6, -1, 1'b1);
        tx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_ss_n", {31'd0, SS_n}, 32'd1);
        check("abort_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("abort_rx_data", {24'd0, rx_data}, 32'd0);
        check("abort_tx_ready", {31'd0, tx_ready}, 32'd1);

        // Normal read afterwards: address 0x10 now holds 0x5A.
        issue(2'b11, 8'h00, 8'h5A, 20, -1, 1'b0);
        tx_valid = 1'b0;

        for (int n = 0; n < 200 && (exp_q.size() != 0 || in_frame); n++) @(posedge clk);
        repeat (30) @(posedge clk);
        #1;
        check("all_frames_seen", exp_q.size(), 32'd0);
        check("final_idle", {31'd0, SS_n}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
